// File: rtl/bcd_7seg_decoder_pkg.sv
// Shared segment types, active-low glyph constants and the code-to-glyph lookup.
// Pattern literals read a..g left to right because index 0 of seg_t is segment a.
package bcd_7seg_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK  = 7'b1111111;
    localparam seg_t SEG_ALL_ON = 7'b0000000;

    localparam seg_t SEG_0 = 7'b0000001;
    localparam seg_t SEG_1 = 7'b1001111;
    localparam seg_t SEG_2 = 7'b0010010;
    localparam seg_t SEG_3 = 7'b0000110;
    localparam seg_t SEG_4 = 7'b1001100;
    localparam seg_t SEG_5 = 7'b0100100;
    localparam seg_t SEG_6 = 7'b0100000;
    localparam seg_t SEG_7 = 7'b0001111;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0000100;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b1100000;
    localparam seg_t SEG_C = 7'b0110001;
    localparam seg_t SEG_D = 7'b1000010;
    localparam seg_t SEG_E = 7'b0110000;
    localparam seg_t SEG_F = 7'b0111000;

    // Unknown codes fall through to the default arm and therefore show blank.
    function automatic seg_t seg_lookup(input logic [3:0] code, input logic hex_en);
        seg_t r_pat;
        r_pat = SEG_BLANK;
        case (code)
            4'd0:  r_pat = SEG_0;
            4'd1:  r_pat = SEG_1;
            4'd2:  r_pat = SEG_2;
            4'd3:  r_pat = SEG_3;
            4'd4:  r_pat = SEG_4;
            4'd5:  r_pat = SEG_5;
            4'd6:  r_pat = SEG_6;
            4'd7:  r_pat = SEG_7;
            4'd8:  r_pat = SEG_8;
            4'd9:  r_pat = SEG_9;
            4'd10: r_pat = hex_en ? SEG_A : SEG_BLANK;
            4'd11: r_pat = hex_en ? SEG_B : SEG_BLANK;
            4'd12: r_pat = hex_en ? SEG_C : SEG_BLANK;
            4'd13: r_pat = hex_en ? SEG_D : SEG_BLANK;
            4'd14: r_pat = hex_en ? SEG_E : SEG_BLANK;
            4'd15: r_pat = hex_en ? SEG_F : SEG_BLANK;
            default: r_pat = SEG_BLANK;
        endcase
        return r_pat;
    endfunction

endpackage

// File: rtl/bcd_7seg_decoder_if.sv
// Digit bus between a display controller (master) and one decoder (slave).
interface bcd_7seg_decoder_if;

    logic               en;
    logic [3:0]         bcd;
    logic               blank;
    logic               lamp_test;
    logic               rbi;
    logic               rbo;
    bcd_7seg_pkg::seg_t seg;

    modport master (
        output en, bcd, blank, lamp_test, rbi,
        input  rbo, seg
    );

    modport slave (
        input  en, bcd, blank, lamp_test, rbi,
        output rbo, seg
    );

endinterface

// File: rtl/bcd_7seg_decoder_lut.sv
// Combinational code-to-glyph table, active-low.
// Codes 10-15 show A..F when HEX_DIGITS_EN is defined, otherwise blank.
module bcd_7seg_lut
    import bcd_7seg_pkg::*;
(
    input  logic [3:0] i_code,
    output seg_t       o_seg
);

`ifdef HEX_DIGITS_EN
    localparam logic HEX_EN = 1'b1;
`else
    localparam logic HEX_EN = 1'b0;
`endif

    assign o_seg = seg_lookup(i_code, HEX_EN);

endmodule

// File: rtl/bcd_7seg_decoder.sv
// Registered BCD to seven-segment decoder for one HEX digit, with lamp test,
// blanking and ripple blanking. Optional A..F glyphs via HEX_DIGITS_EN.
module bcd_7seg_decoder
    import bcd_7seg_pkg::*;
#(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit LEADING_BLANK = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    bcd_7seg_decoder_if.slave   bus
);

    localparam seg_t SEG_RESET = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    seg_t w_lut_seg;
    seg_t w_seg_al;
    seg_t w_seg_next;
    logic w_is_zero;
    logic w_lead_blank;
    logic w_rbo_next;

    seg_t r_seg;
    logic r_rbo;

    bcd_7seg_lut u_lut (
        .i_code (bus.bcd),
        .o_seg  (w_lut_seg)
    );

    // Case compare keeps an unknown code from being treated as zero.
    always_comb begin
        w_is_zero = 1'b0;
        case (bus.bcd)
            4'd0:    w_is_zero = 1'b1;
            default: w_is_zero = 1'b0;
        endcase
    end

    assign w_lead_blank = LEADING_BLANK && bus.rbi && w_is_zero;
    assign w_rbo_next   = w_lead_blank;

    always_comb begin
        w_seg_al = w_lut_seg;
        if (bus.lamp_test) begin
            w_seg_al = SEG_ALL_ON;
        end else if (bus.blank) begin
            w_seg_al = SEG_BLANK;
        end else if (w_lead_blank) begin
            w_seg_al = SEG_BLANK;
        end
    end

    assign w_seg_next = ACTIVE_LOW ? w_seg_al : ~w_seg_al;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_RESET;
            r_rbo <= 1'b0;
        end else if (bus.en) begin
            r_seg <= w_seg_next;
            r_rbo <= w_rbo_next;
        end
    end

    assign bus.seg = r_seg;
    assign bus.rbo = r_rbo;

endmodule

// File: tb/tb_bcd_7seg_decoder.sv
// Scoreboard bench for bcd_7seg_decoder: default, ripple-blanking and
// active-high instances driven in lockstep.
module tb_bcd_7seg_decoder;
    import bcd_7seg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bcd_7seg_decoder_if if_d ();
    bcd_7seg_decoder_if if_lb ();
    bcd_7seg_decoder_if if_ah ();

    bcd_7seg_decoder #(.ACTIVE_LOW(1'b1), .LEADING_BLANK(1'b0)) dut_d (
        .clk (clk), .rst (rst), .bus (if_d)
    );
    bcd_7seg_decoder #(.ACTIVE_LOW(1'b1), .LEADING_BLANK(1'b1)) dut_lb (
        .clk (clk), .rst (rst), .bus (if_lb)
    );
    bcd_7seg_decoder #(.ACTIVE_LOW(1'b0), .LEADING_BLANK(1'b0)) dut_ah (
        .clk (clk), .rst (rst), .bus (if_ah)
    );

    typedef struct {
        string tag;
        seg_t  d;
        seg_t  lb;
        logic  lb_rbo;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    seg_t m_d;
    seg_t m_lb;
    logic m_lb_rbo;
    seg_t tbl [0:15];

    function automatic seg_t model(input logic [3:0] bcd, input logic blank,
                                   input logic lt, input logic rbi, input bit lb);
        if (lt) return 7'b0000000;
        if (blank) return 7'b1111111;
        if ($isunknown(bcd)) return 7'b1111111;
        if (lb && rbi && bcd == 4'd0) return 7'b1111111;
        return tbl[bcd];
    endfunction

    task automatic cmp_seg(input string tag, input seg_t obs, input seg_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cmp_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        cmp_seg({e.tag, "/seg"},    if_d.seg,  e.d);
        cmp_bit({e.tag, "/rbo"},    if_d.rbo,  1'b0);
        cmp_seg({e.tag, "/lb_seg"}, if_lb.seg, e.lb);
        cmp_bit({e.tag, "/lb_rbo"}, if_lb.rbo, e.lb_rbo);
        cmp_seg({e.tag, "/ah_seg"}, if_ah.seg, ~e.d);
    endtask

    task automatic drive(input string tag, input logic [3:0] bcd, input logic en,
                         input logic blank, input logic lt, input logic rbi);
        exp_t e;
        if_d.bcd  = bcd; if_d.en  = en; if_d.blank  = blank; if_d.lamp_test  = lt; if_d.rbi  = rbi;
        if_lb.bcd = bcd; if_lb.en = en; if_lb.blank = blank; if_lb.lamp_test = lt; if_lb.rbi = rbi;
        if_ah.bcd = bcd; if_ah.en = en; if_ah.blank = blank; if_ah.lamp_test = lt; if_ah.rbi = rbi;
        if (en) begin
            m_d      = model(bcd, blank, lt, rbi, 1'b0);
            m_lb     = model(bcd, blank, lt, rbi, 1'b1);
            m_lb_rbo = rbi && (bcd === 4'd0);
        end
        e.tag = tag; e.d = m_d; e.lb = m_lb; e.lb_rbo = m_lb_rbo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        m_d      = 7'b1111111;
        m_lb     = 7'b1111111;
        m_lb_rbo = 1'b0;
    endtask

    initial begin
        tbl[0] = 7'b0000001; tbl[1] = 7'b1001111; tbl[2] = 7'b0010010; tbl[3] = 7'b0000110;
        tbl[4] = 7'b1001100; tbl[5] = 7'b0100100; tbl[6] = 7'b0100000; tbl[7] = 7'b0001111;
        tbl[8] = 7'b0000000; tbl[9] = 7'b0000100;
`ifdef HEX_DIGITS_EN
        tbl[10] = 7'b0001000; tbl[11] = 7'b1100000; tbl[12] = 7'b0110001;
        tbl[13] = 7'b1000010; tbl[14] = 7'b0110000; tbl[15] = 7'b0111000;
`else
        for (int i = 10; i < 16; i++) tbl[i] = 7'b1111111;
`endif
        model_reset();

        if_d.bcd  = 4'd0; if_d.en  = 1'b0; if_d.blank  = 1'b0; if_d.lamp_test  = 1'b0; if_d.rbi  = 1'b0;
        if_lb.bcd = 4'd0; if_lb.en = 1'b0; if_lb.blank = 1'b0; if_lb.lamp_test = 1'b0; if_lb.rbi = 1'b0;
        if_ah.bcd = 4'd0; if_ah.en = 1'b0; if_ah.blank = 1'b0; if_ah.lamp_test = 1'b0; if_ah.rbi = 1'b0;

        #12;
        cmp_seg("reset/seg",    if_d.seg,  7'b1111111);
        cmp_bit("reset/rbo",    if_lb.rbo, 1'b0);
        cmp_seg("reset/lb_seg", if_lb.seg, 7'b1111111);
        cmp_seg("reset/ah_seg", if_ah.seg, 7'b0000000);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            drive($sformatf("dig%0d", i), i[3:0], 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 10; i < 16; i++)
            drive($sformatf("code%0d", i), i[3:0], 1'b1, 1'b0, 1'b0, 1'b0);
        drive("code12", 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);

        drive("lamp_over_blank", 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        drive("blank_only",      4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        drive("release",         4'd5, 1'b1, 1'b0, 1'b0, 1'b0);

        drive("hold_load2", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("hold_bcd9",  4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("hold_gated", 4'd9, 1'b0, 1'b1, 1'b1, 1'b1);
        drive("hold_load9", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);

        drive("rb_zero",     4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive("rb_hold",     4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("rb_four",     4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        drive("rb_zero_rbi0", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("rb_lamp",     4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive("x_code",      4'bxxxx, 1'b1, 1'b0, 1'b0, 1'b1);

        drive("eight", 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        cmp_seg("midreset/seg",    if_d.seg,  7'b1111111);
        cmp_bit("midreset/rbo",    if_lb.rbo, 1'b0);
        cmp_seg("midreset/ah_seg", if_ah.seg, 7'b0000000);
        @(posedge clk);
        #1;
        cmp_seg("reset_held/seg", if_d.seg, 7'b1111111);
        rst = 1'b0;
        drive("post_reset", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_7seg_decoder.md
Name: bcd_7seg_decoder

Overview:
Registered BCD-to-seven-segment decoder driving one DE-board HEX digit; one instance per displayed digit (state digit, four value digits, fixed zero digit). It converts a 4-bit code to segment levels a..g and adds blanking and lamp-test controls. The output is registered so all digits update on the same clock edge.

Parameters:
ACTIVE_LOW, 1, 1 = segment lit when its output bit is 0 (DE-board HEX); 0 = all segment outputs inverted.
LEADING_BLANK, 0, 1 = a code of 0 is shown blank when rbi is high (ripple blanking).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
en  input  1  load enable; register holds its value when low.
bcd  input  4  code to display, bcd[3] = MSB.
blank  input  1  force all segments off.
lamp_test  input  1  force all segments on.
rbi  input  1  ripple-blank in; only used when LEADING_BLANK=1.
rbo  output  1  ripple-blank out: registered (rbi and bcd==0 and LEADING_BLANK).
seg  output  [0:6]  segments; seg[0]=a, seg[1]=b, … seg[6]=g.

Behaviour:
- Reset: asynchronous on rst rising, held while rst=1. seg = all segments off (1111111 with ACTIVE_LOW=1), rbo=0.
- Latency: exactly one clk cycle from inputs sampled with en=1 to seg/rbo.
- en=0: seg and rbo hold their values; blank and lamp_test are also gated by en.
- Priority, highest first: lamp_test (all on), blank (all off), leading blank (off when LEADING_BLANK=1, rbi=1, bcd=0), decode.
- Decode table, active-low pattern a..g (bit0 first):
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Codes 10–15 depend on HEX_DIGITS_EN (see below).
- ACTIVE_LOW=0 is the bitwise inverse of every pattern, including the reset value.
- No X propagation: an unknown bcd value decodes as blank.

Optional Feature:
HEX_DIGITS_EN
- Defined: codes 10–15 display A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Undefined: codes 10–15 display blank (1111111). Required default for the BCD display path.

Decomposition:
- Package bcd_7seg_pkg holds:
  - the segment-vector typedef (7 bits, index 0 = a);
  - named constants SEG_BLANK, SEG_ALL_ON and the per-digit patterns;
  - a pure function seg_lookup(code).
- One combinational sub-module, bcd_7seg_lut, implements the table and the HEX_DIGITS_EN choice.
- The top-level module adds the priority muxing, polarity inversion and the output register.

Test Plan:
- Reset: assert rst mid-run with seg showing "8" -> seg=1111111 immediately, without waiting for a clock edge; rbo=0.
- Sweep: bcd 0..9 with en=1 -> after one clock seg matches the table, e.g. bcd=3 -> 0000110, bcd=7 -> 0001111.
- Out-of-range, bcd=12:
  - macro undefined -> 1111111;
  - macro defined -> 0110001.
- Controls:
  - lamp_test=1 with blank=1 and bcd=5 -> 0000000;
  - blank=1 alone -> 1111111;
  - release both -> 0100100.
- Hold: en=0 while bcd changes 2->9 -> seg stays 0010010; en=1 -> 0000100 after one clock.
- Ripple blanking, LEADING_BLANK=1, rbi=1:
  - bcd=0 -> seg=1111111, rbo=1;
  - bcd=4 -> seg=1001100, rbo=0.
